moy_arbitre: RTL

Time-multiplexed controller that shares one moving-average datapath among several sample sources. The block arbitrates between requesters with round-robin priority and keeps a separate sliding-window history per channel. It sequences a single shared adder over the window and returns the truncated mean tagged with its channel. It sits between the per-channel sample generators and the downstream consumer, in place of one `filtre_moy` instance per channel.

---
 rtl/moy_arbitre_pkg.sv | 11 +
 rtl/moy_arbitre_if.sv | 27 ++
 rtl/moy_arbitre_rr_arb.sv | 30 +++
 rtl/moy_arbitre.sv | 99 +++++++++
 4 files changed

// File: rtl/moy_arbitre_pkg.sv
// moy_pkg: shared constants and types for the moy_arbitre moving-average arbiter
// Holds the default channel count, sample width and window size, plus the FSM state,
// sample and channel-index types used by the arbiter and its interface.
package moy_pkg;
  localparam int NB_CH = 4;
  localparam int W = 8;
  localparam int WIN_LOG2 = 2;
  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;
  typedef logic [W-1:0] sample_t;
  typedef logic [$clog2(NB_CH)-1:0] ch_t;
endpackage

// File: rtl/moy_arbitre_if.sv
// moy_arbitre_if: per-channel sample requests and windowed-mean result handshake
// req_valid/req_data/req_ready : NB_CH requesters, one W-bit sample each, one-hot ready
// m_valid/m_ready/m_data/m_ch  : result stream, mean plus originating channel
// busy                         : arbiter is not idle
// master drives requests and m_ready; slave is the arbiter.
interface moy_arbitre_if #(
  parameter int NB_CH = moy_pkg::NB_CH,
  parameter int W = moy_pkg::W
);
  import moy_pkg::*;
  logic [NB_CH-1:0] req_valid;
  logic [NB_CH-1:0] req_ready;
  logic [NB_CH*W-1:0] req_data;
  logic m_valid;
  logic m_ready;
  logic [W-1:0] m_data;
  logic [$clog2(NB_CH)-1:0] m_ch;
  logic busy;
  modport master (
    output req_valid, req_data, m_ready,
    input  req_ready, m_valid, m_data, m_ch, busy
  );
  modport slave (
    input  req_valid, req_data, m_ready,
    output req_ready, m_valid, m_data, m_ch, busy
  );
endinterface

// File: rtl/moy_arbitre_rr_arb.sv
// moy_rr_arb: combinational round-robin pick starting after the last granted channel
// req  : per-channel request vector
// last : index of the previously granted channel
// gnt  : one-hot grant, zero when nothing is requested
// idx  : granted channel index
// any  : at least one request is present
module moy_rr_arb #(
  parameter int NB_CH = moy_pkg::NB_CH,
  localparam int CW = $clog2(NB_CH)
) (
  input  logic [NB_CH-1:0] req,
  input  logic [CW-1:0]    last,
  output logic [NB_CH-1:0] gnt,
  output logic [CW-1:0]    idx,
  output logic             any
);
  import moy_pkg::*;
  logic [CW-1:0] c;
  // Walk the ring backwards so the closest requester after last wins the final overwrite.
  always_comb begin
    idx = last;
    c = '0;
    for (int i = NB_CH; i >= 1; i--) begin
      c = CW'((int'(last) + i) % NB_CH);
      if (req[c]) idx = c;
    end
  end
  assign any = |req;
  assign gnt = any ? NB_CH'(1) << idx : '0;
endmodule

// File: rtl/moy_arbitre.sv
// moy_arbitre: round-robin shared moving-average datapath over NB_CH sample sources
// clk : rising-edge clock
// rst : synchronous active-high reset, clears state, histories and fill counts
// bus : moy_arbitre_if.slave (requests in, windowed mean and channel out, busy)
// MOY_WARMUP_EN : when defined, a channel emits results only once its window is full.
module moy_arbitre #(
  parameter int NB_CH = moy_pkg::NB_CH,
  parameter int W = moy_pkg::W,
  parameter int WIN_LOG2 = moy_pkg::WIN_LOG2
) (
  input logic clk,
  input logic rst,
  moy_arbitre_if.slave bus
);
  import moy_pkg::*;
  localparam int WIN = 2 ** WIN_LOG2;
  localparam int CW = $clog2(NB_CH);
  state_t state;
  logic [W-1:0] hist [NB_CH][WIN];
  logic [W+WIN_LOG2-1:0] acc;
  logic [W+WIN_LOG2-1:0] acc_nx;
  logic [WIN_LOG2-1:0] k;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] g;
  logic [CW-1:0] pick;
  logic [NB_CH-1:0] gnt;
  logic any;
  logic accept;
  logic full;
  logic [W-1:0] sample;
  moy_rr_arb #(.NB_CH(NB_CH)) u_arb (
    .req (bus.req_valid),
    .last(last_grant),
    .gnt (gnt),
    .idx (pick),
    .any (any)
  );
  assign accept = state == IDLE && any;
  // Ready is gated by rst so nothing is handshaken while reset is being applied.
  assign bus.req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign bus.busy = state != IDLE;
  assign sample = bus.req_data[pick*W +: W];
  assign acc_nx = acc + (W+WIN_LOG2)'(hist[g][k]);
`ifdef MOY_WARMUP_EN
  logic [WIN_LOG2:0] fill [NB_CH];
  logic [WIN_LOG2:0] fill_nx;
  assign fill_nx = fill[pick] == (WIN_LOG2+1)'(WIN) ? fill[pick] : fill[pick] + 1'b1;
  assign full = fill_nx == (WIN_LOG2+1)'(WIN);
  always_ff @(posedge clk)
    if (rst) fill <= '{default: '0};
    else if (accept) fill[pick] <= fill_nx;
`else
  assign full = 1'b1;
`endif
  always_ff @(posedge clk)
    if (rst) hist <= '{default: '0};
    else if (accept) begin
      hist[pick][0] <= sample;
      for (int i = 1; i < WIN; i++) hist[pick][i] <= hist[pick][i-1];
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      k <= '0;
      g <= '0;
      last_grant <= CW'(NB_CH - 1);
      bus.m_valid <= 1'b0;
      bus.m_data <= '0;
      bus.m_ch <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          last_grant <= pick;
          g <= pick;
          acc <= '0;
          k <= '0;
          state <= full ? SUM : IDLE;
        end
        SUM: begin
          acc <= acc_nx;
          k <= k + 1'b1;
          // Last window slot: publish the mean straight from the final partial sum.
          if (&k) begin
            state <= OUT;
            bus.m_valid <= 1'b1;
            bus.m_data <= W'(acc_nx >> WIN_LOG2);
            bus.m_ch <= g;
          end
        end
        OUT: if (bus.m_ready) begin
          state <= IDLE;
          bus.m_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
